uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_rx_core.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// parity mode codes and a parameter legality check used at elaboration.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic bit uart_params_ok(input int data_w, input int cpb,
                                        input int parity, input int stop_bits);
    return (data_w >= 5) && (data_w <= 9) &&
           (cpb >= 4) && ((cpb % 2) == 0) &&
           (parity >= 0) && (parity <= 2) &&
           ((stop_bits == 1) || (stop_bits == 2));
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: after a restart the first strobe lands half a bit later
// (start-bit midpoint), then one strobe every CLKS_PER_BIT cycles while enabled.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
)(
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic restart,
  output logic strobe
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    strobe = en && (cnt_q == '0);
    cnt_d  = cnt_q;
    if (restart)     cnt_d = HALF_LOAD;
    else if (strobe) cnt_d = FULL_LOAD;
    else if (en)     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronised serial input, start/data/parity/stop framing,
// a one-word holding register with valid/ready handshake and error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_data,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_out,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  if (!uart_params_ok(DATA_W, CLKS_PER_BIT, PARITY, STOP_BITS)) begin : g_param_err
    $error("uart_rx_core: illegal parameter combination");
  end

  localparam int BCW = $clog2(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
  localparam bit             HAS_PAR = (PARITY != int'(PAR_NONE));

  // Synchroniser and edge detector
  logic       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0] sync_vld_q, sync_vld_d;
  logic       line_prev_q, line_prev_d;
  logic       line, fall;

  // Framing FSM
  rx_state_e         state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_bit_q, par_bit_d;
  logic              ferr_acc_q, ferr_acc_d;
  logic              timer_en, timer_restart, strobe;
  logic              word_done, par_calc, par_err_w;

  // Holding register
  logic [DATA_W-1:0] rx_out_q, rx_out_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              overrun_q, overrun_d;

  // sync_vld_q marks when sync2_q holds a real line sample rather than the
  // reset value, so a line that is low at reset release is not a start edge.
  always_comb begin
    sync1_d     = rx_data;
    sync2_d     = sync1_q;
    sync_vld_d  = {sync_vld_q[0], 1'b1};
    line        = sync2_q;
    line_prev_d = sync_vld_q[1] ? line : 1'b0;
    fall        = sync_vld_q[1] && line_prev_q && !line;
  end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (timer_en),
    .restart (timer_restart),
    .strobe  (strobe)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    stop_cnt_d    = stop_cnt_q;
    shift_d       = shift_q;
    par_bit_d     = par_bit_q;
    ferr_acc_d    = ferr_acc_q;
    timer_restart = 1'b0;
    word_done     = 1'b0;
    timer_en      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d       = ST_START;
          bit_cnt_d     = '0;
          timer_restart = 1'b1;
        end
      end
      ST_START: begin
        if (strobe) state_d = line ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (strobe) begin
          shift_d   = {line, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = HAS_PAR ? ST_PARITY : ST_STOP;
            stop_cnt_d = 1'b0;
            ferr_acc_d = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        if (strobe) begin
          par_bit_d = line;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (strobe) begin
          if (!line) ferr_acc_d = 1'b1;
          if (stop_cnt_q == LAST_STOP) begin
            word_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    par_calc = (^shift_q) ^ par_bit_q;
    if (PARITY == int'(PAR_EVEN))     par_err_w = par_calc;
    else if (PARITY == int'(PAR_ODD)) par_err_w = ~par_calc;
    else                              par_err_w = 1'b0;
  end

  // A completing word always loads; it only counts as overrun when the held
  // word is not being consumed on this same edge.
  always_comb begin
    rx_out_d     = rx_out_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    if (word_done) begin
      rx_out_d     = shift_q;
      frame_err_d  = ferr_acc_q | ~line;
      parity_err_d = par_err_w;
      rx_valid_d   = 1'b1;
      if (rx_valid_q && !rx_ready) overrun_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      sync_vld_q   <= '0;
      line_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      ferr_acc_q   <= 1'b0;
      rx_out_q     <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync_vld_q   <= sync_vld_d;
      line_prev_q  <= line_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      ferr_acc_q   <= ferr_acc_d;
      rx_out_q     <= rx_out_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_out     = rx_out_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: a no-parity/1-stop instance and an even-parity/2-stop
// instance, driven by a vector table, hand sequences and random frames.
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       line0, line1, rdy0, rdy1;
  logic [7:0] out0, out1;
  logic       vld0, vld1, fe0, fe1, pe0, pe1, ov0, ov1;

  uart_rx_core #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .rx_data(line0), .rx_ready(rdy0),
    .rx_out(out0), .rx_valid(vld0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0));

  uart_rx_core #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .rx_data(line1), .rx_ready(rdy1),
    .rx_out(out1), .rx_valid(vld1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1));

  typedef struct packed { logic [7:0] d; logic fe; logic pe; } rec_t;
  typedef struct {
    int d; logic [7:0] data; int pbit; logic [1:0] stops;
    logic [7:0] ed; logic efe; logic epe;
  } vec_t;

  rec_t got0[$], got1[$], exp_q[$];
  int   vcnt0 = 0, vcnt1 = 0;
  int   checks = 0, errors = 0;

  // Every accepted word (valid && ready) is captured; valid-high cycles are counted.
  always @(negedge clk) begin
    if (vld0) vcnt0++;
    if (vld1) vcnt1++;
    if (vld0 && rdy0) got0.push_back(rec_t'{d: out0, fe: fe0, pe: pe0});
    if (vld1 && rdy1) got1.push_back(rec_t'{d: out1, fe: fe1, pe: pe1});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input int cycles);
    if (d == 0) line0 = v; else line1 = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // dut1 frames carry a parity bit and two stop bits; dut0 uses stops[0] only.
  task automatic send(input int d, input logic [7:0] data, input int pbit, input logic [1:0] stops);
    drive(d, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d, data[i], CPB);
    if (d == 1) drive(d, pbit[0], CPB);
    drive(d, stops[0], CPB);
    if (d == 1) drive(d, stops[1], CPB);
    if (d == 0) line0 = 1'b1; else line1 = 1'b1;
  endtask

  task automatic chk_count(input int d, input string name, input int exp);
    chk(name, (d == 0) ? got0.size() : got1.size(), exp);
  endtask

  task automatic expect_word(input int d, input string name, input logic [7:0] ed,
                             input logic efe, input logic epe);
    rec_t r;
    int   n;
    n = (d == 0) ? got0.size() : got1.size();
    chk({name, " present"}, (n > 0) ? 1 : 0, 1);
    if (n > 0) begin
      r = (d == 0) ? got0.pop_front() : got1.pop_front();
      chk({name, " data"}, r.d, ed);
      chk({name, " frame_err"}, r.fe, efe);
      chk({name, " parity_err"}, r.pe, epe);
    end
  endtask

  initial begin
    vec_t       tbl[8];
    logic [7:0] rd;
    int         pb, gap;
    logic [1:0] st;
    logic       last_low;
    rec_t       e, g;

    tbl[0] = '{d: 0, data: 8'h5A, pbit: 0, stops: 2'b11, ed: 8'h5A, efe: 1'b0, epe: 1'b0};
    tbl[1] = '{d: 1, data: 8'h03, pbit: 1, stops: 2'b11, ed: 8'h03, efe: 1'b0, epe: 1'b1};
    tbl[2] = '{d: 1, data: 8'h03, pbit: 0, stops: 2'b11, ed: 8'h03, efe: 1'b0, epe: 1'b0};
    tbl[3] = '{d: 0, data: 8'hFF, pbit: 0, stops: 2'b10, ed: 8'hFF, efe: 1'b1, epe: 1'b0};
    tbl[4] = '{d: 0, data: 8'h11, pbit: 0, stops: 2'b11, ed: 8'h11, efe: 1'b0, epe: 1'b0};
    tbl[5] = '{d: 1, data: 8'h80, pbit: 0, stops: 2'b01, ed: 8'h80, efe: 1'b1, epe: 1'b1};
    tbl[6] = '{d: 1, data: 8'hA5, pbit: 0, stops: 2'b10, ed: 8'hA5, efe: 1'b1, epe: 1'b0};
    tbl[7] = '{d: 0, data: 8'h00, pbit: 0, stops: 2'b11, ed: 8'h00, efe: 1'b0, epe: 1'b0};

    reset_n = 1'b0; line0 = 1'b1; line1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    idle(4);
    chk("reset dut0 outputs", {out0, vld0, fe0, pe0, ov0}, 0);
    chk("reset dut1 outputs", {out1, vld1, fe1, pe1, ov1}, 0);
    reset_n = 1'b1;
    idle(4);

    foreach (tbl[i]) begin
      vcnt0 = 0; vcnt1 = 0;
      send(tbl[i].d, tbl[i].data, tbl[i].pbit, tbl[i].stops);
      idle(2 * CPB);
      chk_count(tbl[i].d, $sformatf("vec%0d count", i), 1);
      expect_word(tbl[i].d, $sformatf("vec%0d", i), tbl[i].ed, tbl[i].efe, tbl[i].epe);
      chk($sformatf("vec%0d valid cycles", i), (tbl[i].d == 0) ? vcnt0 : vcnt1, 1);
    end

    // Short low glitch on an idle line must not produce a word.
    vcnt0 = 0;
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 3 * CPB);
    chk("glitch no word", got0.size(), 0);
    chk("glitch valid cycles", vcnt0, 0);
    send(0, 8'h5A, 0, 2'b11);
    idle(2 * CPB);
    expect_word(0, "after glitch", 8'h5A, 1'b0, 1'b0);

    // Bad stop bit with the line then held low: no new frame until it goes high.
    drive(0, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(0, 1'b1, CPB);
    drive(0, 1'b0, 4 * CPB);
    drive(0, 1'b1, 2 * CPB);
    send(0, 8'h11, 0, 2'b11);
    idle(2 * CPB);
    chk_count(0, "held low count", 2);
    expect_word(0, "held low bad", 8'hFF, 1'b1, 1'b0);
    expect_word(0, "held low good", 8'h11, 1'b0, 1'b0);

    // Overrun: two words with no consumer.
    rdy0 = 1'b0;
    send(0, 8'h01, 0, 2'b11);
    idle(CPB);
    send(0, 8'h02, 0, 2'b11);
    idle(2 * CPB);
    chk("overrun rx_out", out0, 8'h02);
    chk("overrun rx_valid", vld0, 1);
    chk("overrun flag", ov0, 1);

    // Reset in the middle of data bit 4 of 0xAA.
    drive(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(0, (i % 2 == 1), CPB);
    line0 = 1'b0;
    idle(CPB / 2);
    reset_n = 1'b0;
    #1;
    chk("midframe reset dut0", {out0, vld0, fe0, pe0, ov0}, 0);
    chk("midframe reset dut1", {out1, vld1, fe1, pe1, ov1}, 0);
    idle(3);
    reset_n = 1'b1;
    rdy0 = 1'b1;
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, 3 * CPB);
    chk("post reset no word", got0.size(), 0);
    send(0, 8'h33, 0, 2'b11);
    idle(2 * CPB);
    chk_count(0, "post reset count", 1);
    expect_word(0, "post reset", 8'h33, 1'b0, 1'b0);
    chk("post reset overrun", ov0, 0);

    // Random frames, including back-to-back, against a frame-level model.
    for (int d = 0; d < 2; d++) begin
      exp_q.delete();
      last_low = 1'b0;
      for (int k = 0; k < 20; k++) begin
        rd  = 8'($urandom);
        pb  = int'($urandom_range(0, 1));
        st  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 2 * CPB));
        if (last_low && gap < 2) gap = 2;
        e.d  = rd;
        e.fe = (d == 0) ? ~st[0] : ~(st[0] & st[1]);
        e.pe = (d == 1) ? ((^rd) ^ pb[0]) : 1'b0;
        exp_q.push_back(e);
        idle(gap);
        send(d, rd, pb, st);
        last_low = (d == 0) ? ~st[0] : ~st[1];
      end
      idle(2 * CPB);
      chk_count(d, $sformatf("random dut%0d count", d), 20);
      for (int k = 0; k < 20; k++) begin
        if (((d == 0) ? got0.size() : got1.size()) == 0) break;
        g = (d == 0) ? got0.pop_front() : got1.pop_front();
        e = exp_q[k];
        chk($sformatf("random dut%0d word%0d", d, k), {g.d, g.fe, g.pe}, {e.d, e.fe, e.pe});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
